alu_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one 8-bit ALU between NUM_REQ requesters. Accepts one command
//  at a time over valid/ready, drives the ALU input bus (ce/mode/cmd/op_a/op_b/cin/inp_valid),

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_rr_sched_rr_arbiter.sv | 32 +++
 rtl/alu_rr_sched.sv | 148 ++++++++++++++
 tb/tb_alu_rr_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
// Holds the FSM state encoding, multiply opcodes, command record and response flag bit positions.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  localparam logic [3:0] CMD_MUL_INC = 4'd9;
  localparam logic [3:0] CMD_MUL_SHL = 4'd10;

  typedef struct packed {
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       cin;
    logic       mode;
    logic [3:0] cmd;
    logic [1:0] inp_valid;
  } alu_cmd_t;

  // Bit positions inside rsp_flags = {cout, oflow, err, g, e, l}
  localparam int FLAG_COUT  = 5;
  localparam int FLAG_OFLOW = 4;
  localparam int FLAG_ERR   = 3;
  localparam int FLAG_G     = 2;
  localparam int FLAG_E     = 1;
  localparam int FLAG_L     = 0;

  function automatic logic is_mul_cmd(input logic mode, input logic [3:0] cmd);
    return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
  endfunction

endpackage

// File: rtl/alu_rr_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
// Produces a one-hot grant and the encoded winner index.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] id
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    id    = '0;
    idx   = 0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one 8-bit ALU between NUM_REQ requesters: round-robin accept, issue, fixed-latency
// wait, then hold a tagged response until the consumer takes it.
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*8-1:0]       req_op_a,
  input  logic [NUM_REQ*8-1:0]       req_op_b,
  input  logic [NUM_REQ-1:0]         req_cin,
  input  logic [NUM_REQ-1:0]         req_mode,
  input  logic [NUM_REQ*4-1:0]       req_cmd,
  input  logic [NUM_REQ*2-1:0]       req_inp_valid,
  output logic                       alu_ce,
  output logic [7:0]                 alu_op_a,
  output logic [7:0]                 alu_op_b,
  output logic                       alu_cin,
  output logic                       alu_mode,
  output logic [3:0]                 alu_cmd,
  output logic [1:0]                 alu_inp_valid,
  input  logic [8:0]                 alu_res,
  input  logic                       alu_cout,
  input  logic                       alu_oflow,
  input  logic                       alu_err,
  input  logic                       alu_g,
  input  logic                       alu_e,
  input  logic                       alu_l,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [8:0]                 rsp_res,
  output logic [5:0]                 rsp_flags
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int CNT_W = 8;

  sched_state_t   state_reg;
  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] cmd_id_reg;
  alu_cmd_t       cmd_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic           rsp_valid_reg;
  logic [IDW-1:0] rsp_id_reg;
  logic [8:0]     rsp_res_reg;
  logic [5:0]     rsp_flags_reg;

  alu_cmd_t       req_cmds [NUM_REQ];
  logic [NUM_REQ-1:0] win_grant;
  logic [IDW-1:0] win_id;
  logic           busy;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_cmds[gi] = '{op_a:      req_op_a[8*gi +: 8],
                              op_b:      req_op_b[8*gi +: 8],
                              cin:       req_cin[gi],
                              mode:      req_mode[gi],
                              cmd:       req_cmd[4*gi +: 4],
                              inp_valid: req_inp_valid[2*gi +: 2]};
    end
  endgenerate

  rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (win_grant),
    .id    (win_id)
  );

  assign req_ready = (state_reg == IDLE) ? win_grant : '0;

  // The ALU bus is forced to zero whenever no command is in flight.
  assign busy          = (state_reg == ISSUE) || (state_reg == WAIT);
  assign alu_ce        = busy;
  assign alu_op_a      = busy ? cmd_reg.op_a      : '0;
  assign alu_op_b      = busy ? cmd_reg.op_b      : '0;
  assign alu_cin       = busy ? cmd_reg.cin       : 1'b0;
  assign alu_mode      = busy ? cmd_reg.mode      : 1'b0;
  assign alu_cmd       = busy ? cmd_reg.cmd       : '0;
  assign alu_inp_valid = busy ? cmd_reg.inp_valid : '0;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_res   = rsp_res_reg;
  assign rsp_flags = rsp_flags_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      cmd_id_reg    <= '0;
      cmd_reg       <= '0;
      cnt_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_res_reg   <= '0;
      rsp_flags_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req_valid) begin
            cmd_reg    <= req_cmds[win_id];
            cmd_id_reg <= win_id;
            ptr_reg    <= (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_reg   <= is_mul_cmd(cmd_reg.mode, cmd_reg.cmd) ? CNT_W'(MUL_LAT - 1)
                                                             : CNT_W'(ALU_LAT - 1);
          state_reg <= WAIT;
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            rsp_res_reg                <= alu_res;
            rsp_flags_reg[FLAG_COUT]   <= alu_cout;
            rsp_flags_reg[FLAG_OFLOW]  <= alu_oflow;
            rsp_flags_reg[FLAG_ERR]    <= alu_err;
            rsp_flags_reg[FLAG_G]      <= alu_g;
            rsp_flags_reg[FLAG_E]      <= alu_e;
            rsp_flags_reg[FLAG_L]      <= alu_l;
            rsp_id_reg                 <= cmd_id_reg;
            rsp_valid_reg              <= 1'b1;
            state_reg                  <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched: table of single-requester commands plus hand-written
// sequences for arbitration order, response backpressure, reset mid-flight and idle bus.
module tb_alu_rr_sched;

  localparam int NUM_REQ = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_op_a, req_op_b;
  logic [NUM_REQ-1:0]   req_cin, req_mode;
  logic [NUM_REQ*4-1:0] req_cmd;
  logic [NUM_REQ*2-1:0] req_inp_valid;
  logic                 alu_ce, alu_cin, alu_mode;
  logic [7:0]           alu_op_a, alu_op_b;
  logic [3:0]           alu_cmd;
  logic [1:0]           alu_inp_valid;
  logic [8:0]           alu_res;
  logic                 alu_cout, alu_oflow, alu_err, alu_g, alu_e, alu_l;
  logic                 rsp_valid, rsp_ready;
  logic [1:0]           rsp_id;
  logic [8:0]           rsp_res;
  logic [5:0]           rsp_flags;

  int checks = 0;
  int errors = 0;
  logic [23:0] first_bus;

  always #5 clk = ~clk;

  alu_rr_sched #(.NUM_REQ(NUM_REQ), .ALU_LAT(1), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_cin(req_cin), .req_mode(req_mode),
    .req_cmd(req_cmd), .req_inp_valid(req_inp_valid),
    .alu_ce(alu_ce), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_cin(alu_cin),
    .alu_mode(alu_mode), .alu_cmd(alu_cmd), .alu_inp_valid(alu_inp_valid),
    .alu_res(alu_res), .alu_cout(alu_cout), .alu_oflow(alu_oflow), .alu_err(alu_err),
    .alu_g(alu_g), .alu_e(alu_e), .alu_l(alu_l),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags)
  );

  // Behavioural ALU: result is only meaningful once the bus has been enabled for the
  // command's latency; before that it shows all-ones garbage.
  int ce_cnt = 0;
  always @(posedge clk) ce_cnt <= alu_ce ? ce_cnt + 1 : 0;

  function automatic logic [14:0] alu_model(input logic mode, input logic [3:0] cmd,
                                            input logic [7:0] a, input logic [7:0] b,
                                            input logic cin, input logic [1:0] iv);
    logic [8:0]  r;
    logic [5:0]  f;
    logic [15:0] p;
    r = '0; f = '0; p = '0;
    if (iv == 2'b00) f[3] = 1'b1;
    else if (mode) begin
      case (cmd)
        4'd0:  begin r = {1'b0, a} + {1'b0, b}; f[5] = r[8]; end
        4'd1:  r = {1'b0, a} - {1'b0, b};
        4'd2:  begin r = {1'b0, a} + {1'b0, b} + {8'b0, cin}; f[5] = r[8]; end
        4'd8:  begin f[2] = a > b; f[1] = a == b; f[0] = a < b; end
        4'd9:  begin p = ({8'b0, a} + 16'd1) * ({8'b0, b} + 16'd1); r = p[8:0]; end
        4'd10: begin p = ({8'b0, a} << 1) * {8'b0, b}; r = p[8:0]; end
        default: f[3] = 1'b1;
      endcase
    end else begin
      case (cmd)
        4'd0: r = {1'b0, a & b};
        4'd1: r = {1'b0, a | b};
        4'd2: r = {1'b0, a ^ b};
        default: f[3] = 1'b1;
      endcase
    end
    return {r, f};
  endfunction

  logic [14:0] alu_out;
  int          need;
  always_comb begin
    need = (alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10)) ? 2 : 1;
    if (alu_ce && ce_cnt >= need)
      alu_out = alu_model(alu_mode, alu_cmd, alu_op_a, alu_op_b, alu_cin, alu_inp_valid);
    else
      alu_out = 15'h7FFF;
  end
  assign alu_res   = alu_out[14:6];
  assign alu_cout  = alu_out[5];
  assign alu_oflow = alu_out[4];
  assign alu_err   = alu_out[3];
  assign alu_g     = alu_out[2];
  assign alu_e     = alu_out[1];
  assign alu_l     = alu_out[0];

  typedef struct {
    int         req;
    logic       mode;
    logic [3:0] cmd;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [1:0] iv;
    logic [8:0] res;
    logic [5:0] flags;
    int         lat;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic mode, input logic [3:0] cmd,
                         input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [1:0] iv);
    req_op_a[8*r +: 8]      = a;
    req_op_b[8*r +: 8]      = b;
    req_cin[r]              = cin;
    req_mode[r]             = mode;
    req_cmd[4*r +: 4]       = cmd;
    req_inp_valid[2*r +: 2] = iv;
    req_valid[r]            = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Counts negedges after the accept cycle until rsp_valid; records the first ALU bus image.
  task automatic wait_rsp(output int n, output int ce_n);
    n = 0; ce_n = 0; first_bus = '0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (alu_ce === 1'b1) begin
        if (ce_n == 0)
          first_bus = {alu_op_a, alu_op_b, alu_cin, alu_mode, alu_cmd, alu_inp_valid};
        ce_n++;
      end
      if (rsp_valid === 1'b1) break;
    end
    if (rsp_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL rsp_timeout actual=%0b expected=1", rsp_valid);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n, ce_n;
    @(posedge clk); #1;
    set_req(v.req, v.mode, v.cmd, v.a, v.b, v.cin, v.iv);
    @(negedge clk);
    chk("vec_grant", 32'(req_ready), 32'(1 << v.req));
    @(posedge clk); #1 req_valid = '0;
    wait_rsp(n, ce_n);
    chk("vec_latency", n, 2 + v.lat);
    chk("vec_ce_cycles", ce_n, 1 + v.lat);
    chk("vec_bus", 32'(first_bus), 32'({v.a, v.b, v.cin, v.mode, v.cmd, v.iv}));
    chk("vec_id", 32'(rsp_id), v.req);
    chk("vec_res", 32'(rsp_res), 32'(v.res));
    chk("vec_flags", 32'(rsp_flags), 32'(v.flags));
    $display("txn req=%0d mode=%0d cmd=%0d a=%0d b=%0d -> id=%0d res=%0d flags=%b lat=%0d",
             v.req, v.mode, v.cmd, v.a, v.b, rsp_id, rsp_res, rsp_flags, n);
  endtask

  task automatic grant_and_rsp(input int exp_id, input logic [8:0] exp_res);
    int n, ce_n;
    @(negedge clk);
    chk("rr_grant", 32'(req_ready), 32'(1 << exp_id));
    @(posedge clk); #1 req_valid[exp_id] = 1'b0;
    wait_rsp(n, ce_n);
    chk("rr_id", 32'(rsp_id), exp_id);
    chk("rr_res", 32'(rsp_res), 32'(exp_res));
    $display("txn rr grant=%0d -> id=%0d res=%0d", exp_id, rsp_id, rsp_res);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, ce_n;
    vecs[0]  = '{0, 1'b1, 4'd0,  8'd10,  8'd20,  1'b0, 2'b11, 9'd30,  6'b000000, 1};
    vecs[1]  = '{1, 1'b1, 4'd9,  8'd3,   8'd4,   1'b0, 2'b11, 9'd20,  6'b000000, 2};
    vecs[2]  = '{2, 1'b1, 4'd0,  8'd200, 8'd100, 1'b0, 2'b11, 9'd300, 6'b100000, 1};
    vecs[3]  = '{3, 1'b1, 4'd2,  8'd1,   8'd2,   1'b1, 2'b11, 9'd4,   6'b000000, 1};
    vecs[4]  = '{0, 1'b1, 4'd8,  8'd5,   8'd9,   1'b0, 2'b11, 9'd0,   6'b000001, 1};
    vecs[5]  = '{1, 1'b0, 4'd0,  8'hF0,  8'h3C,  1'b0, 2'b11, 9'h030, 6'b000000, 1};
    vecs[6]  = '{2, 1'b0, 4'd2,  8'hF0,  8'h3C,  1'b0, 2'b11, 9'h0CC, 6'b000000, 1};
    vecs[7]  = '{3, 1'b1, 4'd10, 8'd3,   8'd5,   1'b0, 2'b11, 9'd30,  6'b000000, 2};
    vecs[8]  = '{0, 1'b1, 4'd15, 8'd1,   8'd1,   1'b0, 2'b11, 9'd0,   6'b001000, 1};
    vecs[9]  = '{1, 1'b1, 4'd0,  8'd1,   8'd1,   1'b0, 2'b00, 9'd0,   6'b001000, 1};
    vecs[10] = '{2, 1'b1, 4'd1,  8'd9,   8'd4,   1'b0, 2'b11, 9'd5,   6'b000000, 1};

    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = '0; req_op_a = '0; req_op_b = '0; req_cin = '0; req_mode = '0;
    req_cmd = '0; req_inp_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_alu_bus", 32'({alu_ce, alu_op_a, alu_op_b, alu_cin, alu_mode, alu_cmd,
                              alu_inp_valid}), 0);
    chk("reset_rsp_data", 32'({rsp_id, rsp_res, rsp_flags}), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // All four requesters at once from ptr=0, then req0+req3 with ptr back at 0.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'd0, 8'(i * 10), 8'd1, 1'b0, 2'b11);
    for (int k = 0; k < 4; k++) grant_and_rsp(k, 9'(k * 10 + 1));
    set_req(0, 1'b1, 4'd0, 8'd5, 8'd5, 1'b0, 2'b11);
    set_req(3, 1'b1, 4'd0, 8'd7, 8'd7, 1'b0, 2'b11);
    grant_and_rsp(0, 9'd10);
    grant_and_rsp(3, 9'd14);

    // Response held under backpressure while another requester waits.
    rsp_ready = 1'b0;
    set_req(2, 1'b1, 4'd0, 8'd7, 8'd8, 1'b0, 2'b11);
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1 req_valid[2] = 1'b0;
    set_req(1, 1'b1, 4'd0, 8'd1, 8'd1, 1'b0, 2'b11);
    wait_rsp(n, ce_n);
    chk("bp_latency", n, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp", 32'({rsp_id, rsp_res}), 32'({2'd2, 9'd15}));
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_alu_ce", 32'(alu_ce), 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_after_rsp_valid", 32'(rsp_valid), 0);
    chk("bp_next_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    wait_rsp(n, ce_n);
    chk("bp_second", 32'({rsp_id, rsp_res}), 32'({2'd1, 9'd2}));
    $display("txn backpressure second id=%0d res=%0d", rsp_id, rsp_res);
    @(posedge clk); #1;

    // Reset while a multiply is in WAIT; req2 stays valid and is granted again afterwards.
    set_req(2, 1'b1, 4'd9, 8'd2, 8'd2, 1'b0, 2'b11);
    @(negedge clk);
    chk("rst_grant", 32'(req_ready), 32'b0100);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_alu_ce", 32'(alu_ce), 0);
    chk("rst_regrant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1 req_valid[2] = 1'b0;
    wait_rsp(n, ce_n);
    chk("rst_latency", n, 4);
    chk("rst_rsp", 32'({rsp_id, rsp_res}), 32'({2'd2, 9'd9}));
    $display("txn after reset id=%0d res=%0d", rsp_id, rsp_res);
    @(posedge clk); #1;

    // Quiet period: bus must be driven to zero, not X.
    req_valid = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_alu_bus", 32'({alu_ce, alu_op_a, alu_op_b, alu_cin, alu_mode, alu_cmd,
                               alu_inp_valid}), 0);
      chk("idle_rsp_ready", 32'({rsp_valid, req_ready}), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
